// File: rtl/tree_sum_accumulator_pkg.sv
// Shared definitions for the adder-tree blocks: default datapath widths and
// the accumulator FSM state type.
package tree_sum_accumulator_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_MAX_LEN = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/tree_sum_accumulator_if.sv
// Sum-in / result-out handshake bundle of the tree-sum accumulator.
// The accumulator takes the slave side; the producer/consumer takes the master side.
interface tree_sum_accumulator_if
  import tree_sum_accumulator_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) ();

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic signed [IN_W-1:0]  sum_i;
  logic                    sum_valid_i;
  logic                    sum_ready_o;
  logic [CNT_W-1:0]        len_i;
  logic signed [ACC_W-1:0] res_o;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic                    busy_o;

  modport slave (
    input  sum_i, sum_valid_i, len_i, res_ready_i,
    output sum_ready_o, res_o, res_valid_o, busy_o
  );

  modport master (
    output sum_i, sum_valid_i, len_i, res_ready_i,
    input  sum_ready_o, res_o, res_valid_o, busy_o
  );

endinterface

// File: rtl/tree_sum_len_counter.sv
// Down-counter of beats still owed to the current accumulation, with load,
// decrement and a flag marking that the next beat is the last one.
module tree_sum_len_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates a run of len_i signed adder-tree sums into one result, presented
// with a valid/ready handshake; a new run may start on the cycle the result leaves.
module tree_sum_accumulator
  import tree_sum_accumulator_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input logic                   clk_i,
  input logic                   rst_i,
  tree_sum_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  acc_state_e              state;
  logic signed [ACC_W-1:0] acc;
  logic                    res_valid;
  logic                    busy;

  logic                    beat;
  logic                    first_beat;
  logic                    transfer;
  logic                    cnt_last;
  logic signed [ACC_W-1:0] sum_ext;
  logic [CNT_W-1:0]        len_clamped;
  logic [CNT_W-1:0]        load_val;

  // Size cast of a signed operand sign-extends into the accumulator width.
  assign sum_ext = ACC_W'(bus.sum_i);

  assign bus.sum_ready_o = (state != ST_HOLD) || bus.res_ready_i;
  assign beat            = bus.sum_valid_i && bus.sum_ready_o;
  assign transfer        = res_valid && bus.res_ready_i;
  // A beat accepted in HOLD implies res_ready_i, so it always rides on a transfer.
  assign first_beat      = beat && (state != ST_ACCUM);

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    len_clamped = bus.len_i;
    if (bus.len_i > CNT_W'(MAX_LEN)) begin
      len_clamped = CNT_W'(MAX_LEN);
    end
    load_val = (len_clamped == '0) ? '0 : len_clamped - CNT_W'(1);
  end

  tree_sum_len_counter #(
    .CNT_W (CNT_W)
  ) u_len_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (first_beat),
    .load_val (load_val),
    .dec      (beat && (state == ST_ACCUM)),
    .last     (cnt_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      acc       <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (first_beat) begin
            acc  <= sum_ext;
            busy <= 1'b1;
            if (load_val == '0) begin
              state     <= ST_HOLD;
              res_valid <= 1'b1;
            end else begin
              state     <= ST_ACCUM;
              res_valid <= 1'b0;
            end
          end else if (transfer) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc <= acc + sum_ext;
            if (cnt_last) begin
              state     <= ST_HOLD;
              res_valid <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_o       = acc;
  assign bus.res_valid_o = res_valid;
  assign bus.busy_o      = busy;

endmodule
